// File: rtl/line_pkg.sv
// Constants and types shared by the line-buffered UART transmit path.
package line_pkg;

   localparam logic [7:0]  CH_LF = 8'h0A;
   localparam logic [7:0]  CH_CR = 8'h0D;
   localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd868;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

   function automatic logic is_eol(input logic [7:0] ch);
      return (ch == CH_LF) || (ch == CH_CR);
   endfunction

endpackage

// File: rtl/uart_serializer.sv
// 8N1 UART serializer: takes one byte per i_stb while idle, drives a registered tx line.
// state | meaning
// IDLE  | line high, accepts i_stb
// START | start bit, line low
// DATA  | eight data bits, LSB first
// STOP  | stop bit, line high, then IDLE
module uart_serializer
   import line_pkg::*;
#(
   parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_stb,
   input  logic [7:0] i_data,
   output logic       o_idle,
   output logic       o_uart_tx
);

   localparam logic [23:0] BAUD_RELOAD = CLOCKS_PER_BAUD - 24'd1;

   ser_state_t  state, state_next;
   logic [23:0] baud_cnt, baud_cnt_next;
   logic [2:0]  bit_idx, bit_idx_next;
   logic [7:0]  shreg, shreg_next;
   logic        tx_next;
   logic        baud_tc;

   assign baud_tc = (baud_cnt == 24'd0);
   assign o_idle  = (state == IDLE);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         o_uart_tx <= 1'b1;
      end else begin
         state     <= state_next;
         baud_cnt  <= baud_cnt_next;
         bit_idx   <= bit_idx_next;
         shreg     <= shreg_next;
         o_uart_tx <= tx_next;
      end
   end

   always_comb begin
      state_next    = state;
      baud_cnt_next = baud_cnt;
      bit_idx_next  = bit_idx;
      shreg_next    = shreg;
      tx_next       = o_uart_tx;
      case (state)
         IDLE: begin
            if (i_stb) begin
               state_next    = START;
               baud_cnt_next = BAUD_RELOAD;
               bit_idx_next  = '0;
               shreg_next    = i_data;
               tx_next       = 1'b0;
            end
         end
         START: begin
            if (baud_tc) begin
               state_next    = DATA;
               baud_cnt_next = BAUD_RELOAD;
               tx_next       = shreg[0];
            end else begin
               baud_cnt_next = baud_cnt - 24'd1;
            end
         end
         DATA: begin
            if (baud_tc) begin
               baud_cnt_next = BAUD_RELOAD;
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
                  tx_next      = shreg[bit_idx_next];
               end
            end else begin
               baud_cnt_next = baud_cnt - 24'd1;
            end
         end
         STOP: begin
            if (baud_tc) begin
               state_next = IDLE;
            end else begin
               baud_cnt_next = baud_cnt - 24'd1;
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/line_sender.sv
// Line-buffered UART transmitter: bytes wait in a FIFO until a line is committed
// (CR/LF, MAXLINE characters, or flush) and are then serialized as 8N1.
module line_sender
   import line_pkg::*;
#(
   parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
   parameter int          LGFLEN          = 8,
   parameter int          MAXLINE         = 80
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_wr,
   input  logic [7:0]        i_data,
   input  logic              i_flush,
   output logic              o_full,
   output logic [LGFLEN:0]   o_fill,
   output logic              o_busy,
   output logic              o_err,
   output logic              o_uart_tx
);

   localparam int              DEPTH     = 1 << LGFLEN;
   localparam logic [LGFLEN:0] FULL_FILL = (LGFLEN+1)'(DEPTH);
   localparam logic [LGFLEN:0] MAXLINE_W = (LGFLEN+1)'(MAXLINE);
   localparam logic [LGFLEN:0] ONE       = (LGFLEN+1)'(1);
   localparam logic [LGFLEN-1:0] PTR_ONE = LGFLEN'(1);

   logic [7:0]        mem [DEPTH];
   logic [LGFLEN-1:0] wr_ptr, rd_ptr;
   logic [LGFLEN:0]   fill, pend, cmt;
   logic [LGFLEN:0]   pend_next, cmt_next, commit_amt, pend_inc;
   logic              ser_idle, pop, accept;

   assign o_fill = fill;
   assign o_full = (fill == FULL_FILL);
   assign pop    = ser_idle && (cmt != '0);
   // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
   assign accept = i_wr && (!o_full || pop);
   assign o_busy = (cmt != '0) || !ser_idle;

   always_comb begin
      pend_inc   = pend + ONE;
      pend_next  = pend;
      commit_amt = '0;
      if (accept) begin
         if (is_eol(i_data) || (pend_inc == MAXLINE_W)) begin
            commit_amt = pend_inc;
            pend_next  = '0;
         end else begin
            pend_next = pend_inc;
         end
      end
      if (i_flush) begin
         commit_amt = commit_amt + pend_next;
         pend_next  = '0;
      end
      cmt_next = cmt - (pop ? ONE : '0) + commit_amt;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
         pend   <= '0;
         cmt    <= '0;
         o_err  <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
         fill <= fill + (accept ? ONE : '0) - (pop ? ONE : '0);
         pend <= pend_next;
         cmt  <= cmt_next;
         if (i_wr && !accept) o_err <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) mem[wr_ptr] <= i_data;
   end

   uart_serializer #(
      .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
   ) u_ser (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_stb     (pop),
      .i_data    (mem[rd_ptr]),
      .o_idle    (ser_idle),
      .o_uart_tx (o_uart_tx)
   );

endmodule

// File: tb/tb_line_sender.sv
// Directed bench for line_sender: vector table plus hand-written multi-frame sequences.
`timescale 1ns/1ps
module tb_line_sender;

   localparam int CPB   = 24;
   localparam int CPB_B = 4;
   localparam int PER   = 10;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr    = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       flush = 1'b0;
   logic       full, busy, err, tx;
   logic [8:0] fill;

   logic       wr_b    = 1'b0;
   logic [7:0] data_b  = 8'h00;
   logic       flush_b = 1'b0;
   logic       full_b, busy_b, err_b, tx_b;
   logic [8:0] fill_b;

   always #(PER/2) clk = ~clk;

   line_sender #(.CLOCKS_PER_BAUD(24'(CPB)), .LGFLEN(8), .MAXLINE(80)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_wr(wr), .i_data(data), .i_flush(flush),
      .o_full(full), .o_fill(fill), .o_busy(busy), .o_err(err), .o_uart_tx(tx));

   line_sender #(.CLOCKS_PER_BAUD(24'(CPB_B)), .LGFLEN(8), .MAXLINE(80)) u_burst (
      .i_clk(clk), .i_reset_n(rst_n), .i_wr(wr_b), .i_data(data_b), .i_flush(flush_b),
      .o_full(full_b), .o_fill(fill_b), .o_busy(busy_b), .o_err(err_b), .o_uart_tx(tx_b));

   int          nchecks = 0;
   int          nerrors = 0;
   int          inv_viol = 0;
   int          full_viol = 0;
   int          frame_err = 0;
   logic [7:0]  rx_q[$], rxb_q[$], exp_q[$];
   longint      rx_t[$], rxb_t[$];
   longint      t_idle;

   typedef struct packed {
      logic       w;
      logic [7:0] d;
      logic       f;
      logic [8:0] e_fill;
      logic       e_busy;
      logic       e_tx;
      logic       e_full;
      logic       e_err;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input longint act, input longint exp);
      nchecks++;
      if (act != exp) begin
         nerrors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic get_tx(input bit fast);
      return fast ? tx_b : tx;
   endfunction

   // Polling UART receiver; start edge time recorded at the clock edge tx fell on.
   task automatic rx_loop(input bit fast);
      int         cpb;
      logic [7:0] b;
      longint     t0;
      cpb = fast ? CPB_B : CPB;
      forever begin
         @(posedge clk); #1;
         if (rst_n && get_tx(fast) == 1'b0) begin
            t0 = longint'($time) - 1;
            repeat (cpb/2) @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
               repeat (cpb) @(posedge clk);
               #1;
               b[i] = get_tx(fast);
            end
            repeat (cpb) @(posedge clk);
            #1;
            if (get_tx(fast) != 1'b1) frame_err++;
            if (fast) begin
               rxb_q.push_back(b);
               rxb_t.push_back(t0);
            end else begin
               rx_q.push_back(b);
               rx_t.push_back(t0);
            end
         end
      end
   endtask

   initial rx_loop(1'b0);
   initial rx_loop(1'b1);

   always @(negedge clk) begin
      if (rst_n) begin
         if ((10'(dut.pend) + 10'(dut.cmt)) != 10'(fill)) inv_viol++;
         if ((10'(u_burst.pend) + 10'(u_burst.cmt)) != 10'(fill_b)) inv_viol++;
         if (full != (fill == 9'd256)) full_viol++;
         if (full_b != (fill_b == 9'd256)) full_viol++;
      end
   end

   task automatic clear_rx();
      rx_q.delete(); rx_t.delete(); rxb_q.delete(); rxb_t.delete();
   endtask

   task automatic chk_rx(input string name, input bit fast);
      int n;
      n = fast ? rxb_q.size() : rx_q.size();
      chk({name, " frame count"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++)
         chk($sformatf("%s byte %0d", name, i), fast ? rxb_q[i] : rx_q[i], exp_q[i]);
   endtask

   task automatic wr_byte(input logic [7:0] b, input bit fl);
      wr = 1'b1; data = b; flush = fl;
      @(posedge clk); #1;
      wr = 1'b0; flush = 1'b0;
   endtask

   task automatic wait_idle(input bit fast, input int budget, input string name);
      int n = 0;
      while ((fast ? busy_b : busy) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      t_idle = longint'($time);
      if (n >= budget) chk({name, " busy after timeout"}, fast ? busy_b : busy, 0);
   endtask

   function automatic logic [7:0] ch81(input int i);
      return 8'h41 + 8'(i % 26);
   endfunction

   initial begin
      #(150000 * PER);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int         bad, late, notx, peak, full_seen, n;
      logic [8:0] fill_end;
      longint     t_end, t_start;

      //              w     d      f     fill   busy  tx    full  err
      vecs[0] = '{1'b0, 8'h00, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 8'h48, 1'b0, 9'd1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 8'h49, 1'b0, 9'd2, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h0A, 1'b0, 9'd3, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 1'b0, 9'd2, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 9'd2, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 8'h00, 1'b0, 9'd2, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 8'h00, 1'b0, 9'd2, 1'b1, 1'b0, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state, "HI\n" commit on LF, start bit two clocks after LF is presented
      for (int i = 0; i < 8; i++) begin
         wr = vecs[i].w; data = vecs[i].d; flush = vecs[i].f;
         @(posedge clk); #1;
         wr = 1'b0; flush = 1'b0;
         chk($sformatf("vec %0d {fill,busy,tx,full,err}", i),
             {fill, busy, tx, full, err},
             {vecs[i].e_fill, vecs[i].e_busy, vecs[i].e_tx, vecs[i].e_full, vecs[i].e_err});
      end
      wait_idle(1'b0, 1500, "hi");
      exp_q = '{8'h48, 8'h49, 8'h0A};
      chk_rx("hi", 1'b0);
      if (rx_t.size() == 3) begin
         chk("hi start spacing 0-1", (rx_t[1] - rx_t[0]) / PER, 241);
         chk("hi start spacing 1-2", (rx_t[2] - rx_t[1]) / PER, 241);
         chk("hi busy fall after last start", (t_idle - rx_t[2]) / PER, 240);
      end

      // "ABCDE" held without terminator, then flushed
      clear_rx();
      for (int i = 0; i < 5; i++) wr_byte(8'h41 + 8'(i), 1'b0);
      bad = 0;
      for (int i = 0; i < 10000; i++) begin
         @(posedge clk); #1;
         if (tx != 1'b1 || busy != 1'b0) bad++;
      end
      chk("abcde line held", bad, 0);
      chk("abcde fill while held", fill, 5);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_idle(1'b0, 2000, "abcde");
      exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
      chk_rx("abcde", 1'b0);
      chk("abcde fill drained", fill, 0);

      // flush in the same cycle as a write includes that byte
      clear_rx();
      wr_byte(8'h47, 1'b1);
      chk("write+flush busy", busy, 1);
      wait_idle(1'b0, 1000, "write+flush");
      exp_q = '{8'h47};
      chk_rx("write+flush", 1'b0);
      chk("write+flush fill", fill, 0);

      // MAXLINE commit: 81 plain bytes, only the first 80 go out
      clear_rx();
      bad = 0;
      for (int i = 0; i < 81; i++) begin
         wr_byte(ch81(i), 1'b0);
         if (i < 80 && tx != 1'b1) bad++;
      end
      chk("maxline quiet before 80th commit", bad, 0);
      chk("maxline start bit after 80th", tx, 0);
      wait_idle(1'b0, 20000, "maxline");
      exp_q.delete();
      for (int i = 0; i < 80; i++) exp_q.push_back(ch81(i));
      chk_rx("maxline", 1'b0);
      chk("maxline 81st pending fill", fill, 1);
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (tx != 1'b1) bad++;
      end
      chk("maxline 81st not sent", bad, 0);
      clear_rx();
      wr_byte(8'h0D, 1'b0);
      wait_idle(1'b0, 1000, "maxline cr");
      exp_q = '{ch81(80), 8'h0D};
      chk_rx("maxline cr", 1'b0);
      chk("maxline cr fill", fill, 0);

      // burst of 300 'x' into the fast instance
      clear_rx();
      peak = 0; full_seen = 0;
      for (int i = 0; i < 300; i++) begin
         wr_b = 1'b1; data_b = 8'h78;
         @(posedge clk); #1;
         if (int'(fill_b) > peak) peak = int'(fill_b);
         if (full_b) full_seen = 1;
      end
      wr_b = 1'b0;
      t_end = longint'($time) - 1;
      fill_end = fill_b;
      chk("burst peak fill", peak, 256);
      chk("burst full seen", full_seen, 1);
      chk("burst err sticky", err_b, 1);
      flush_b = 1'b1;
      @(posedge clk); #1;
      flush_b = 1'b0;
      wait_idle(1'b1, 15000, "burst");
      late = 0; notx = 0;
      foreach (rxb_t[i]) if (rxb_t[i] > t_end) late++;
      foreach (rxb_q[i]) if (rxb_q[i] != 8'h78) notx++;
      chk("burst frames after burst vs bytes held", late, fill_end);
      chk("burst non-x bytes", notx, 0);
      chk("burst fill drained", fill_b, 0);
      chk("burst err still set", err_b, 1);

      // LF written in the pop cycle with cmt=1, pend=3
      clear_rx();
      wr_byte(8'h5A, 1'b0);
      wr_byte(8'h0A, 1'b0);
      wr_byte(8'h70, 1'b0);
      chk("corner first start", tx, 0);
      t_start = longint'($time) - 1;
      wr_byte(8'h71, 1'b0);
      wr_byte(8'h72, 1'b0);
      repeat (238) @(posedge clk);
      #1;
      chk("corner cycle position", (longint'($time) - t_start) / PER, 240);
      chk("corner cmt before", dut.cmt, 1);
      chk("corner pend before", dut.pend, 3);
      wr_byte(8'h0A, 1'b0);
      chk("corner cmt after", dut.cmt, 4);
      chk("corner pend after", dut.pend, 0);
      chk("corner fill after", fill, 4);
      chk("corner second start", tx, 0);
      wait_idle(1'b0, 2000, "corner");
      exp_q = '{8'h5A, 8'h0A, 8'h70, 8'h71, 8'h72, 8'h0A};
      chk_rx("corner", 1'b0);

      // reset in the middle of a frame's data bits
      clear_rx();
      wr_byte(8'h41, 1'b0);
      wr_byte(8'h0A, 1'b0);
      n = 0;
      while (tx != 1'b0 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reset test frame started", tx, 0);
      repeat (100) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("reset tx high", tx, 1);
      chk("reset fill", fill, 0);
      chk("reset err", err, 0);
      chk("reset burst err", err_b, 0);
      chk("reset busy", busy, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      clear_rx();
      wr_byte(8'h4F, 1'b0);
      wr_byte(8'h4B, 1'b0);
      wr_byte(8'h0A, 1'b0);
      wait_idle(1'b0, 1500, "after reset");
      exp_q = '{8'h4F, 8'h4B, 8'h0A};
      chk_rx("after reset", 1'b0);

      chk("pend+cmt==fill violations", inv_viol, 0);
      chk("full flag violations", full_viol, 0);
      chk("stop bit errors", frame_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
